// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg
// Shared types and defaults for the frame streamer slice.
//   state_t   : controller state encoding (EMPTY / FULL / STREAM)
//   DEF_*     : default pixel width and frame geometry
//   ptr_w()   : bit width needed to index n entries (minimum 1)
package frame_streamer_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_IMG_WIDTH  = 8;
  localparam int DEF_IMG_HEIGHT = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_streamer_buffer.sv
// frame_buffer
// Pixel storage for one frame. The array has no reset, so its contents
// survive resets and state changes.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module frame_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer
// Captures one IMG_WIDTH x IMG_HEIGHT frame through a load port and replays
// it in raster order as a valid/ready pixel stream with row/col position,
// last-pixel marker and an end-of-frame done pulse.
//
// Build option: define FRAME_STREAMER_REPLAY_EN to return to FULL after each
// frame, so the stored frame can be replayed without reloading. Without it
// the controller returns to EMPTY and a new frame must be loaded.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   load_data/valid     : pixel load input; load_ready high while EMPTY
//   start               : request one replay (acted on only in FULL)
//   pix_data/valid/ready: output stream; pix_last on the final pixel
//   row, col            : raster position of pix_data
//   busy                : streaming
//   done                : one-cycle pulse after the last pixel is accepted
//
// state  | meaning
// EMPTY  | accepting pixels into the buffer
// FULL   | frame stored, waiting for start
// STREAM | presenting pixels to the consumer
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int INPUT_NUM  = IMG_WIDTH * IMG_HEIGHT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  load_data,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic                              start,
  output logic [WIDTH-1:0]                  pix_data,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic                              pix_last,
  output logic [ptr_w(IMG_HEIGHT)-1:0]      row,
  output logic [ptr_w(IMG_WIDTH)-1:0]       col,
  output logic                              busy,
  output logic                              done
);

  localparam int PTR_W = ptr_w(INPUT_NUM);
  localparam int RW    = ptr_w(IMG_HEIGHT);
  localparam int CW    = ptr_w(IMG_WIDTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(INPUT_NUM - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_WIDTH - 1);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             wr_en, accept, last_accept, start_go;

  assign wr_en       = (state == EMPTY) && load_valid;
  assign accept      = (state == STREAM) && pix_ready;
  assign last_accept = accept && (rd_ptr == LAST_IDX);
  // While done is high the state may already be FULL again; ignoring start
  // for that cycle keeps done from coinciding with the next frame's setup.
  assign start_go    = (state == FULL) && start && !done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (wr_en && (wr_ptr == LAST_IDX)) state_nxt = FULL;
      FULL:    if (start_go) state_nxt = STREAM;
      STREAM:
        if (last_accept) begin
`ifdef FRAME_STREAMER_REPLAY_EN
          state_nxt = FULL;
`else
          state_nxt = EMPTY;
`endif
        end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      row    <= '0;
      col    <= '0;
      done   <= 1'b0;
    end else begin
      done <= last_accept;
      if (wr_en) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (start_go || last_accept) begin
        rd_ptr <= '0;
        row    <= '0;
        col    <= '0;
      end else if (accept) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  frame_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (INPUT_NUM),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign load_ready = (state == EMPTY);
  assign pix_valid  = (state == STREAM);
  assign busy       = (state == STREAM);
  // Buffer is unreset, so gate the read data to keep pix_data at 0 when idle.
  assign pix_data   = pix_valid ? rdata : '0;
  assign pix_last   = pix_valid && (rd_ptr == LAST_IDX);

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;
  localparam int WIDTH = 8;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int N     = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready = 1'b1;
  logic             pix_last;
  logic [2:0]       row;
  logic [2:0]       col;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  frame_streamer #(
    .WIDTH(WIDTH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .row        (row),
    .col        (col),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes base, base+1, ... into the buffer, one pixel per cycle.
  task automatic load_frame(input logic [7:0] base);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(i);
      step();
      if (i == N - 2) chk("load_ready_before_last", 32'(load_ready), 32'd1);
    end
    load_valid = 1'b0;
    chk("load_ready_after_last", 32'(load_ready), 32'd0);
  endtask

  // Expects pixel 0 already presented; checks count pixels with ready high.
  task automatic stream_check(input logic [7:0] base, input int count);
    pix_ready = 1'b1;
    for (int k = 0; k < count; k++) begin
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pix_data", 32'(pix_data), 32'(base + 8'(k)));
      chk("row", 32'(row), 32'(k / IW));
      chk("col", 32'(col), 32'(k % IW));
      chk("pix_last", 32'(pix_last), 32'(k == N - 1));
      chk("done_in_stream", 32'(done), 32'd0);
      if (k < count - 1) step();
    end
  endtask

  initial begin
    int k;
    int cyc;

    // Reset state
    step();
    step();
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_last", 32'(pix_last), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // start in EMPTY has no effect
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_start_valid", 32'(pix_valid), 32'd0);
    chk("empty_start_ready", 32'(load_ready), 32'd1);

    // Load 1..64, then load_valid in FULL must be ignored
    load_frame(8'd1);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    load_valid = 1'b0;
    chk("full_idle_valid", 32'(pix_valid), 32'd0);
    chk("full_idle_ready", 32'(load_ready), 32'd0);

    // start held high through the whole frame: single replay
    start = 1'b1;
    step();
    chk("busy_stream", 32'(busy), 32'd1);
    chk("mid_row8_pre", 32'(pix_data), 32'd1);
    stream_check(8'd1, N);
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_no_valid", 32'(pix_valid), 32'd0);
    chk("done_row", 32'(row), 32'd0);
    chk("done_col", 32'(col), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
`ifdef FRAME_STREAMER_REPLAY_EN
    chk("replay_done_ready", 32'(load_ready), 32'd0);
    step();
    chk("replay_gap_done", 32'(done), 32'd0);
    chk("replay_gap_valid", 32'(pix_valid), 32'd0);
    step();
    start = 1'b0;
    stream_check(8'd1, N);
    step();
    chk("replay_done", 32'(done), 32'd1);
`else
    chk("done_load_ready", 32'(load_ready), 32'd1);
    step();
    chk("after_done_pulse", 32'(done), 32'd0);
    chk("after_done_valid", 32'(pix_valid), 32'd0);
    chk("after_done_ready", 32'(load_ready), 32'd1);
    start = 1'b0;
`endif

    // Return to a known EMPTY state for both builds
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Back-pressure: ready toggles every cycle
    load_frame(8'h80);
    start = 1'b1;
    step();
    start = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 400) begin
      pix_ready = (cyc % 2 == 0);
      chk("bp_valid", 32'(pix_valid), 32'd1);
      chk("bp_data", 32'(pix_data), 32'(8'h80 + 8'(k)));
      chk("bp_col", 32'(col), 32'(k % IW));
      chk("bp_last", 32'(pix_last), 32'(k == N - 1));
      step();
      if (pix_ready) k++;
      cyc++;
    end
    pix_ready = 1'b1;
    chk("bp_accept_count", 32'(k), 32'(N));
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_done_valid", 32'(pix_valid), 32'd0);
    step();
    chk("bp_done_single", 32'(done), 32'd0);

    // Reset mid-stream at pixel 30
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_frame(8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    stream_check(8'd1, 30);
    step();
    chk("pix30_data", 32'(pix_data), 32'd31);
    reset = 1'b1;
    step();
    chk("abort_valid", 32'(pix_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(load_ready), 32'd1);
    chk("abort_data", 32'(pix_data), 32'd0);
    reset = 1'b0;

    // Partial load aborted by reset, then a fresh full load
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hA0;
      step();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_load_ready", 32'(load_ready), 32'd1);
    load_frame(8'h40);
    start = 1'b1;
    step();
    start = 1'b0;
    stream_check(8'h40, N);
    step();
    chk("fresh_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
